// File: rtl/if_bpu_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcodes, link
// registers, counter reset value and the return-stack action encoding.
package if_bpu_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  localparam logic [1:0] CTR_RESET = 2'b01;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POP_PUSH
  } ras_op_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/if_bpu_if.sv
// Fetch/EX-side bundle of the branch predictor; master is the pipeline,
// slave is the predictor.
interface if_bpu_if #(
  parameter int XLEN = 32
);

  logic            if_valid_i;
  logic            if_fire_i;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_instr_i;
  logic            flush_i;
  logic            ex_upd_valid_i;
  logic [XLEN-1:0] ex_upd_pc_i;
  logic            ex_upd_taken_i;
  logic            bpu_taken_o;
  logic [XLEN-1:0] bpu_target_o;
  logic            bpu_ctrl_o;
  logic            bpu_jalr_miss_o;

  modport master (
    output if_valid_i, if_fire_i, if_pc_i, if_instr_i, flush_i,
           ex_upd_valid_i, ex_upd_pc_i, ex_upd_taken_i,
    input  bpu_taken_o, bpu_target_o, bpu_ctrl_o, bpu_jalr_miss_o
  );

  modport slave (
    input  if_valid_i, if_fire_i, if_pc_i, if_instr_i, flush_i,
           ex_upd_valid_i, ex_upd_pc_i, ex_upd_taken_i,
    output bpu_taken_o, bpu_target_o, bpu_ctrl_o, bpu_jalr_miss_o
  );

endinterface

// File: rtl/if_bpu_predec.sv
// Predecoder: classifies control-flow instructions and extracts rd, rs1 and
// the sign-extended immediate that matches the instruction type.
module if_bpu_predec #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_branch,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [XLEN-1:0] imm
);
  import if_bpu_pkg::*;

  always_comb begin
    is_jal    = (instr[6:0] == OPC_JAL);
    is_jalr   = (instr[6:0] == OPC_JALR);
    is_branch = (instr[6:0] == OPC_BRANCH);
    rd        = instr[11:7];
    rs1       = instr[19:15];
    imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
    if (is_jal) begin
      imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    end else if (is_branch) begin
      imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    end
  end

endmodule

// File: rtl/if_bpu.sv
// Fetch-stage branch predictor: bimodal (or static BTFN) direction, circular
// return-address stack and a same-cycle next-PC mux.
module if_bpu #(
  parameter int XLEN      = 32,
  parameter bit BHT_EN    = 1'b1,
  parameter int BHT_DEPTH = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  if_bpu_if.slave   bus
);
  import if_bpu_pkg::*;

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic            is_jal, is_jalr, is_branch;
  logic [4:0]      rd, rs1;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_plus4, pc_plus_imm;
  logic            rd_link, rs1_link;
  ras_op_e         ras_op;
  logic            bht_taken;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, top_idx, ptr_next;
  logic [CNT_W-1:0] ras_cnt;
  logic            ras_hit, commit;

  if_bpu_predec #(.XLEN(XLEN)) u_predec (
    .instr     (bus.if_instr_i),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .is_branch (is_branch),
    .rd        (rd),
    .rs1       (rs1),
    .imm       (imm)
  );

  assign pc_plus4    = bus.if_pc_i + XLEN'(4);
  assign pc_plus_imm = bus.if_pc_i + imm;
  assign rd_link     = is_link(rd);
  assign rs1_link    = is_link(rs1);
  assign top_idx     = (ras_ptr == '0) ? PTR_LAST : ras_ptr - 1'b1;
  assign ptr_next    = (ras_ptr == PTR_LAST) ? '0 : ras_ptr + 1'b1;
  assign ras_hit     = (ras_cnt != '0);
  assign commit      = bus.if_valid_i & bus.if_fire_i;

  // A JALR with identical link rd/rs1 is a call, not a return.
  always_comb begin
    ras_op = RAS_NONE;
    if ((is_jal | is_jalr) & rd_link) begin
      ras_op = RAS_PUSH;
    end
    if (is_jalr & rs1_link & ~(rd_link & (rd == rs1))) begin
      ras_op = rd_link ? RAS_POP_PUSH : RAS_POP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || bus.flush_i) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (commit) begin
      if (ras_op == RAS_PUSH || (ras_op == RAS_POP_PUSH && !ras_hit)) begin
        ras_ptr <= ptr_next;
        if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_op == RAS_POP && ras_hit) begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && !bus.flush_i && commit) begin
      if (ras_op == RAS_PUSH || (ras_op == RAS_POP_PUSH && !ras_hit)) begin
        ras_mem[ras_ptr] <= pc_plus4;
      end else if (ras_op == RAS_POP_PUSH) begin
        ras_mem[top_idx] <= pc_plus4;
      end
    end
  end

  if (BHT_EN) begin : g_bht
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             unused_upd_pc;

    assign rd_idx        = bus.if_pc_i[IDX_W+1:2];
    assign wr_idx        = bus.ex_upd_pc_i[IDX_W+1:2];
    assign unused_upd_pc = ^{bus.ex_upd_pc_i[XLEN-1:IDX_W+2], bus.ex_upd_pc_i[1:0]};
    // Reads see the pre-update counter; there is deliberately no bypass.
    assign bht_taken     = bht[rd_idx][1];

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_RESET;
      end else if (bus.ex_upd_valid_i) begin
        if (bus.ex_upd_taken_i && bht[wr_idx] != 2'b11) begin
          bht[wr_idx] <= bht[wr_idx] + 2'd1;
        end else if (!bus.ex_upd_taken_i && bht[wr_idx] != 2'b00) begin
          bht[wr_idx] <= bht[wr_idx] - 2'd1;
        end
      end
    end
  end else begin : g_btfn
    logic unused_upd;
    assign unused_upd = ^{bus.ex_upd_valid_i, bus.ex_upd_pc_i, bus.ex_upd_taken_i};
    assign bht_taken  = imm[XLEN-1];
  end

  always_comb begin
    bus.bpu_taken_o     = 1'b0;
    bus.bpu_ctrl_o      = 1'b0;
    bus.bpu_jalr_miss_o = 1'b0;
    bus.bpu_target_o    = pc_plus4;
    if (rst_n_i && bus.if_valid_i) begin
      bus.bpu_ctrl_o = is_jal | is_jalr | is_branch;
      if (is_jal || (is_branch && bht_taken)) begin
        bus.bpu_taken_o  = 1'b1;
        bus.bpu_target_o = pc_plus_imm;
      end else if (is_jalr) begin
        if ((ras_op == RAS_POP || ras_op == RAS_POP_PUSH) && ras_hit) begin
          bus.bpu_taken_o  = 1'b1;
          bus.bpu_target_o = {ras_mem[top_idx][XLEN-1:1], 1'b0};
        end else begin
          bus.bpu_jalr_miss_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_bpu.sv
// Self-checking bench for if_bpu: directed scenarios plus randomized traffic
// against a queue/array reference model, on a bimodal and a static instance.
module tb_if_bpu;

  typedef struct packed {
    logic        taken;
    logic        ctrl;
    logic        miss;
    logic [31:0] target;
  } pred_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_bpu_if #(.XLEN(32)) bus_a ();
  if_bpu_if #(.XLEN(32)) bus_b ();

  if_bpu #(.XLEN(32), .BHT_EN(1'b1), .BHT_DEPTH(64), .RAS_DEPTH(4)) dut_a (
    .clk_i (clk), .rst_n_i (rst_n), .bus (bus_a.slave)
  );
  if_bpu #(.XLEN(32), .BHT_EN(1'b0), .BHT_DEPTH(64), .RAS_DEPTH(4)) dut_b (
    .clk_i (clk), .rst_n_i (rst_n), .bus (bus_b.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic        s_valid, s_fire, s_flush, s_uv, s_ut;
  logic [31:0] s_pc, s_instr, s_upc;

  int          bht_m [64];
  logic [31:0] ras_q [$];
  pred_t       got, exp_p;

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic bit link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic set_in(input logic v, input logic f, input logic [31:0] pc,
                        input logic [31:0] instr, input logic fl, input logic uv,
                        input logic [31:0] upc, input logic ut);
    s_valid = v; s_fire = f; s_pc = pc; s_instr = instr;
    s_flush = fl; s_uv = uv; s_upc = upc; s_ut = ut;
    bus_a.if_valid_i = v; bus_a.if_fire_i = f; bus_a.if_pc_i = pc; bus_a.if_instr_i = instr;
    bus_a.flush_i = fl; bus_a.ex_upd_valid_i = uv; bus_a.ex_upd_pc_i = upc; bus_a.ex_upd_taken_i = ut;
    bus_b.if_valid_i = v; bus_b.if_fire_i = f; bus_b.if_pc_i = pc; bus_b.if_instr_i = instr;
    bus_b.flush_i = fl; bus_b.ex_upd_valid_i = uv; bus_b.ex_upd_pc_i = upc; bus_b.ex_upd_taken_i = ut;
  endtask

  function automatic pred_t obs(input bit use_b);
    if (use_b) return {bus_b.bpu_taken_o, bus_b.bpu_ctrl_o, bus_b.bpu_jalr_miss_o, bus_b.bpu_target_o};
    return {bus_a.bpu_taken_o, bus_a.bpu_ctrl_o, bus_a.bpu_jalr_miss_o, bus_a.bpu_target_o};
  endfunction

  // Expected prediction for the current stimulus from ISA rules and model state.
  function automatic pred_t model_predict(input bit bht_en);
    pred_t p;
    logic signed [20:0] ij;
    logic signed [12:0] ib;
    logic [4:0] rd, rs1;
    p = {1'b0, 1'b0, 1'b0, s_pc + 32'd4};
    if (!s_valid) return p;
    ij  = {s_instr[31], s_instr[19:12], s_instr[20], s_instr[30:21], 1'b0};
    ib  = {s_instr[31], s_instr[7], s_instr[30:25], s_instr[11:8], 1'b0};
    rd  = s_instr[11:7];
    rs1 = s_instr[19:15];
    case (s_instr[6:0])
      7'b1101111: begin
        p.ctrl = 1'b1; p.taken = 1'b1; p.target = s_pc + 32'(int'(ij));
      end
      7'b1100011: begin
        p.ctrl = 1'b1;
        if (bht_en ? (bht_m[(s_pc / 4) % 64] >= 2) : (ib < 0)) begin
          p.taken = 1'b1; p.target = s_pc + 32'(int'(ib));
        end
      end
      7'b1100111: begin
        p.ctrl = 1'b1;
        if (link(rs1) && !(link(rd) && rd == rs1) && ras_q.size() > 0) begin
          p.taken = 1'b1; p.target = ras_q[ras_q.size()-1] & 32'hFFFF_FFFE;
        end else begin
          p.miss = 1'b1;
        end
      end
      default: ;
    endcase
    return p;
  endfunction

  task automatic model_commit();
    logic [4:0] rd, rs1;
    bit is_j, is_jr, push, pop;
    int idx;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      ras_q.delete();
      return;
    end
    if (s_uv) begin
      idx = (s_upc / 4) % 64;
      if (s_ut && bht_m[idx] < 3) bht_m[idx]++;
      if (!s_ut && bht_m[idx] > 0) bht_m[idx]--;
    end
    if (s_flush) begin
      ras_q.delete();
    end else if (s_valid && s_fire) begin
      rd    = s_instr[11:7];
      rs1   = s_instr[19:15];
      is_j  = (s_instr[6:0] == 7'b1101111);
      is_jr = (s_instr[6:0] == 7'b1100111);
      push  = (is_j || is_jr) && link(rd);
      pop   = is_jr && link(rs1) && !(link(rd) && rd == rs1);
      if (pop && push && ras_q.size() > 0) begin
        ras_q[ras_q.size()-1] = s_pc + 32'd4;
      end else if (push) begin
        if (ras_q.size() == 4) void'(ras_q.pop_front());
        ras_q.push_back(s_pc + 32'd4);
      end else if (pop && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
    end
  endtask

  task automatic cycle();
    model_commit();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 1, 32'h1000, enc_j(5'd1, 21'h100), 0, 0, 0, 0);
    #1;
    got = obs(0); n_cmp++;
    if (got[34:32] !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags_a got=%b want=000", got[34:32]);
    end
    got = obs(1); n_cmp++;
    if (got[34:32] !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags_b got=%b want=000", got[34:32]);
    end
    cycle(); cycle();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_idle_wrap();
    set_in(0, 1, 32'hFFFF_FFFC, enc_j(5'd1, 21'h100), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b0, 1'b0, 1'b0, 32'h0}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL invalid_fetch got=%h want=%h", got, exp_p); end
    cycle();
    set_in(1, 1, 32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 0, 0);
    #1; got = obs(0); n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL non_ctrl_wrap got=%h want=%h", got, exp_p); end
    cycle();
  endtask

  task automatic test_jal_jalr();
    set_in(1, 1, 32'h1000, enc_j(5'd1, 21'h100), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'h1100}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL jal_call got=%h want=%h", got, exp_p); end
    cycle();
    set_in(1, 1, 32'h1100, enc_jalr(5'd0, 5'd1), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'h1004}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL jalr_return got=%h want=%h", got, exp_p); end
    cycle();
    #1; got = obs(0); exp_p = {1'b0, 1'b1, 1'b1, 32'h1104}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL jalr_empty got=%h want=%h", got, exp_p); end
    cycle();
  endtask

  task automatic test_bht();
    set_in(1, 0, 32'h2000, enc_b(13'h1FF8), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b0, 1'b1, 1'b0, 32'h2004}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL bht_weak_nt got=%h want=%h", got, exp_p); end
    got = obs(1); exp_p = {1'b1, 1'b1, 1'b0, 32'h1FF8}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL btfn_backward got=%h want=%h", got, exp_p); end
    cycle();
    set_in(0, 0, 0, 0, 0, 1, 32'h2000, 1);
    cycle(); cycle();
    set_in(1, 0, 32'h2000, enc_b(13'h1FF8), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'h1FF8}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL bht_strong_t got=%h want=%h", got, exp_p); end
    cycle();
    set_in(0, 0, 0, 0, 0, 1, 32'h2000, 0);
    cycle(); cycle(); cycle();
    set_in(1, 0, 32'h2000, enc_b(13'h1FF8), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b0, 1'b1, 1'b0, 32'h2004}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL bht_strong_nt got=%h want=%h", got, exp_p); end
    set_in(1, 0, 32'h2000, enc_b(13'h0008), 0, 0, 0, 0);
    #1; got = obs(1); n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL btfn_forward got=%h want=%h", got, exp_p); end
    cycle();
  endtask

  task automatic test_ras_overflow();
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 32'(i * 16), enc_j(5'd1, 21'h100), 0, 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 32'h800, enc_jalr(5'd0, 5'd1), 0, 0, 0, 0);
      #1; got = obs(0);
      exp_p = (i < 4) ? {1'b1, 1'b1, 1'b0, 32'h44 - 32'(i * 16)} : {1'b0, 1'b1, 1'b1, 32'h804};
      n_cmp++;
      if (got !== exp_p) begin n_fail++; $display("[TB] FAIL ras_pop%0d got=%h want=%h", i, got, exp_p); end
      cycle();
    end
  endtask

  task automatic test_flush_stall();
    set_in(1, 1, 32'h500, enc_j(5'd1, 21'h100), 0, 0, 0, 0);
    cycle();
    set_in(1, 1, 32'h600, enc_j(5'd5, 21'h100), 1, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'h700}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL flush_cycle got=%h want=%h", got, exp_p); end
    cycle();
    set_in(1, 0, 32'h900, enc_j(5'd1, 21'h100), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'hA00}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL stalled_jal got=%h want=%h", got, exp_p); end
    cycle(); cycle();
    set_in(1, 1, 32'hA00, enc_jalr(5'd0, 5'd1), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b0, 1'b1, 1'b1, 32'hA04}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL after_flush_stall got=%h want=%h", got, exp_p); end
    cycle();
  endtask

  task automatic test_same_cycle();
    set_in(1, 0, 32'h3010, enc_b(13'h1FF8), 0, 1, 32'h3010, 1);
    #1; got = obs(0); exp_p = {1'b0, 1'b1, 1'b0, 32'h3014}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL no_bypass got=%h want=%h", got, exp_p); end
    cycle();
    set_in(1, 0, 32'h3010, enc_b(13'h1FF8), 0, 0, 0, 0);
    #1; got = obs(0); exp_p = {1'b1, 1'b1, 1'b0, 32'h3008}; n_cmp++;
    if (got !== exp_p) begin n_fail++; $display("[TB] FAIL post_update got=%h want=%h", got, exp_p); end
    cycle();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd2;
    endcase
  endfunction

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 9) < 7) return 32'h4000 + ($urandom_range(0, 7) << 2);
    return $urandom;
  endfunction

  task automatic test_random();
    logic [31:0] instr;
    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      case ($urandom_range(0, 3))
        0: begin instr[11:7] = pick_reg(); instr[6:0] = 7'b1101111; end
        1: begin instr[11:7] = pick_reg(); instr[19:15] = pick_reg(); instr[6:0] = 7'b1100111; end
        2: instr[6:0] = 7'b1100011;
        default: instr[6:0] = 7'b0010011;
      endcase
      set_in(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 9) < 7), pick_pc(), instr,
             logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)), pick_pc(),
             logic'($urandom_range(0, 1)));
      #1;
      got = obs(0); exp_p = model_predict(1'b1); n_cmp++;
      if (got !== exp_p) begin n_fail++; $display("[TB] FAIL rand_bimodal[%0d] got=%h want=%h", n, got, exp_p); end
      got = obs(1); exp_p = model_predict(1'b0); n_cmp++;
      if (got !== exp_p) begin n_fail++; $display("[TB] FAIL rand_static[%0d] got=%h want=%h", n, got, exp_p); end
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #2;
    test_reset();
    test_idle_wrap();
    test_jal_jalr();
    test_bht();
    test_ras_overflow();
    test_flush_stall();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_bpu.md
Name: if_bpu

Overview:
Fetch-stage branch prediction unit. It predecodes the fetched instruction and produces a same-cycle next-PC prediction for JAL, JALR and conditional branches. Branch direction comes from a PC-indexed bimodal table of 2-bit counters, or from static backward-taken/forward-not-taken when the table is disabled. Returns are predicted by a circular return-address stack. It sits between the fetch PC register and the I-side request logic; the EX stage trains it.

Parameters:
XLEN, 32, datapath and PC width
BHT_EN, 1, 1 = bimodal table; 0 = static BTFN (no counters instantiated)
BHT_DEPTH, 64, number of 2-bit counters; power of 2, at least 2
RAS_DEPTH, 4, return-address stack entries; at least 1

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
if_valid_i  in  1  if_pc_i/if_instr_i hold a valid fetched instruction
if_fire_i  in  1  fetch advances this cycle; commits RAS push/pop
if_pc_i  in  XLEN  PC of fetched instruction
if_instr_i  in  32  fetched instruction
flush_i  in  1  pipeline redirect; empties the RAS
ex_upd_valid_i  in  1  EX resolved a conditional branch
ex_upd_pc_i  in  XLEN  PC of the resolved branch
ex_upd_taken_i  in  1  resolved direction
bpu_taken_o  out  1  predict redirect
bpu_target_o  out  XLEN  predicted next PC
bpu_ctrl_o  out  1  instruction is JAL, JALR or a branch
bpu_jalr_miss_o  out  1  JALR with no RAS prediction (fetch must stall or fall through)

Behaviour:
- Reset (rst_n_i=0 at an edge): all counters become 2'b01 (weak not-taken); RAS ptr=0, count=0. While rst_n_i=0, bpu_taken_o, bpu_ctrl_o and bpu_jalr_miss_o are forced to 0.
- Predecode uses opcode[6:0]: 1101111 is JAL, 1100111 is JALR, 1100011 is a branch. J/B/I immediates are sign-extended to XLEN.
- Link register: rd or rs1 equals x1 or x5.
- All outputs are combinational, with zero latency from if_*. When if_valid_i=0, all flags are 0 and bpu_target_o = if_pc_i+4.
- JAL: taken, target = pc+immJ.
- Branch, BHT_EN=1: taken = counter[pc[log2(BHT_DEPTH)+1:2]][1], target = pc+immB.
- Branch, BHT_EN=0: taken = immB sign bit.
- Not taken: bpu_target_o = pc+4. All address arithmetic wraps mod 2^XLEN.
- JALR action is decided from rd and rs1:
  - rd not link, rs1 link: pop.
  - rd link, rs1 not link: push.
  - both link, rd != rs1: pop then push.
  - both link, rd == rs1: push.
- JALR prediction: if a pop is implied and count>0, taken with target = RAS top, bit 0 cleared. Otherwise taken=0 and bpu_jalr_miss_o=1.
- RAS update is sequential and happens only at the edge where if_valid_i & if_fire_i.
  - Push writes pc+4 at ptr and advances ptr mod RAS_DEPTH. count saturates at RAS_DEPTH; overflow overwrites the oldest entry.
  - Pop on count=0 is a no-op.
  - Pop+push replaces the top entry; ptr and count are unchanged when count>0. With count=0 it acts as a push.
  - JAL with rd link also pushes.
- flush_i: at the next edge count=0, ptr=0. flush_i wins over a simultaneous fire.
- BHT update on ex_upd_valid_i: index from ex_upd_pc_i. Saturating +1 when taken, -1 when not; saturates at 11 and 00.
- A same-cycle read and update of one index returns the old value; no bypass.
- A fetch stall (if_fire_i=0) leaves all state unchanged; outputs track the inputs.

Decomposition:
- Shared defines header holds: opcode constants for JAL/JALR/BRANCH, link register indices 1 and 5, counter reset value 2'b01.
- Sub-module if_bpu_predec (combinational): produces is_jal/is_jalr/is_branch, rd/rs1 indices and sign-extended immediate.
- if_bpu holds the BHT array, RAS and prediction mux.

Test Plan:
- Reset, then JAL x1,+0x100 at pc 0x1000 with fire -> taken, target 0x1100; next cycle RAS count 1, top 0x1004.
- JALR x0,0(x1) at pc 0x1100 after the above -> taken, target 0x1004, count returns to 0; a repeated JALR -> bpu_jalr_miss_o=1, taken=0.
- BHT_EN=1: branch at 0x2000 offset -8 -> not taken (counter 01); two EX taken updates at 0x2000 -> counter 11, taken, target 0x1FF8; three not-taken updates -> 00, predicts not taken.
- BHT_EN=0: branch offset -8 -> taken; offset +8 -> not taken, target pc+4.
- RAS_DEPTH=4: five pushes from pcs 0x0,0x10,0x20,0x30,0x40 -> pops return 0x44,0x34,0x24,0x14, then miss.
- Flush with a simultaneous push fire -> count 0 afterwards; an update to the index being read in the same cycle -> the old prediction is shown that cycle.
